// File: rtl/alu.sv
// RV32I integer ALU: ten register/immediate operations on 32-bit operands.
// Result and zero flag are combinational, with a registered copy of both.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [3:0]  ALUop,
    output logic [31:0] ALUresult,
    output logic        zero,
    output logic [31:0] ALUresult_q,
    output logic        zero_q
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;

    // Only the low five bits of op2 form the shift amount; a shift of 32 acts as 0.
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic        w_zero;
    logic [31:0] r_result;
    logic        r_zero;

    assign w_shamt = op2[4:0];

    always_comb begin
        w_result = 32'h0;
        case (ALUop)
            OP_ADD:  w_result = op1 + op2;
            OP_SUB:  w_result = op1 - op2;
            OP_SLL:  w_result = op1 << w_shamt;
            OP_SLT:  w_result = {31'b0, $signed(op1) < $signed(op2)};
            OP_SLTU: w_result = {31'b0, op1 < op2};
            OP_XOR:  w_result = op1 ^ op2;
            OP_SRL:  w_result = op1 >> w_shamt;
            OP_SRA:  w_result = $unsigned($signed(op1) >>> w_shamt);
            OP_OR:   w_result = op1 | op2;
            OP_AND:  w_result = op1 & op2;
            default: w_result = 32'h0;
        endcase
    end

    assign w_zero    = (w_result == 32'h0);
    assign ALUresult = w_result;
    assign zero      = w_zero;

    // Reset clears only the registered copy; zero_q reads 0 during reset, not 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= 32'h0;
            r_zero   <= 1'b0;
        end else begin
            r_result <= w_result;
            r_zero   <= w_zero;
        end
    end

    assign ALUresult_q = r_result;
    assign zero_q      = r_zero;

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, register/reset sequences,
// and randomized operations against an arithmetic reference model.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ALUop;
    logic [31:0] ALUresult;
    logic        zero;
    logic [31:0] ALUresult_q;
    logic        zero_q;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vecs[$];

    alu dut (
        .clk        (clk),
        .rst        (rst),
        .op1        (op1),
        .op2        (op2),
        .ALUop      (ALUop),
        .ALUresult  (ALUresult),
        .zero       (zero),
        .ALUresult_q(ALUresult_q),
        .zero_q     (zero_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
        longint m  = 64'h1_0000_0000;
        longint ua = a;
        longint ub = b;
        longint sa = a;
        longint sb = b;
        longint pw = 1;
        longint r  = 0;
        int     sh = int'(b % 32);
        if (a[31]) sa = ua - m;
        if (b[31]) sb = ub - m;
        for (int i = 0; i < sh; i++) pw = pw * 2;
        case (op)
            4'd0: r = (ua + ub) % m;
            4'd1: r = (ua - ub + m) % m;
            4'd2: r = (ua * pw) % m;
            4'd3: r = (sa < sb) ? 1 : 0;
            4'd4: r = (ua < ub) ? 1 : 0;
            4'd5: r = longint'(a ^ b);
            4'd6: r = ua / pw;
            4'd7: begin
                if (sa >= 0) r = sa / pw;
                else         r = -((-sa + pw - 1) / pw);
                r = (r + m) % m;
            end
            4'd8: r = longint'(a | b);
            4'd9: r = longint'(a & b);
            default: r = 0;
        endcase
        return r[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input logic [31:0] r, input logic z);
        vec_t v;
        v.a = a; v.b = b; v.op = op; v.exp_res = r; v.exp_zero = z;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] tbl_res [10];
        n_cmp = 0;
        n_bad = 0;

        tbl_res = '{32'd15, 32'd5, 32'd320, 32'd0, 32'd0, 32'd15, 32'd0, 32'd0, 32'd15, 32'd0};
        for (int i = 0; i < 10; i++)
            add_vec(32'd10, 32'd5, 4'(i), tbl_res[i], tbl_res[i] == 32'd0);
        add_vec(32'hFFFF_FFF6, 32'd5, 4'd3, 32'd1, 1'b0);
        add_vec(32'hFFFF_FFF6, 32'd5, 4'd4, 32'd0, 1'b1);
        add_vec(32'hFFFF_FFF6, 32'd5, 4'd6, 32'h07FF_FFFF, 1'b0);
        add_vec(32'hFFFF_FFF6, 32'd5, 4'd7, 32'hFFFF_FFFF, 1'b0);
        add_vec(32'hFFFF_FFF6, 32'd5, 4'd0, 32'hFFFF_FFFB, 1'b0);
        add_vec(32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 1'b1);
        add_vec(32'd0, 32'd1, 4'd1, 32'hFFFF_FFFF, 1'b0);
        add_vec(32'd1, 32'd33, 4'd2, 32'd2, 1'b0);
        add_vec(32'h8000_0000, 32'd32, 4'd7, 32'h8000_0000, 1'b0);
        for (int i = 10; i < 16; i++)
            add_vec(32'hDEAD_BEEF, 32'h1234_5678, 4'(i), 32'd0, 1'b1);

        // Reset: registered outputs held clear across clock edges.
        rst = 1'b1; op1 = 32'd10; op2 = 32'd5; ALUop = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_result_q", ALUresult_q, 32'd0);
        chk("reset_zero_q", {31'b0, zero_q}, 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            op1 = vecs[i].a; op2 = vecs[i].b; ALUop = vecs[i].op;
            #1;
            $display("vec %0d: op=%0d a=%h b=%h -> res=%h zero=%0b", i, ALUop, op1, op2,
                     ALUresult, zero);
            chk($sformatf("vec%0d_result", i), ALUresult, vecs[i].exp_res);
            chk($sformatf("vec%0d_zero", i), {31'b0, zero}, {31'b0, vecs[i].exp_zero});
        end

        // Registered path: capture on a clock edge, then hold while inputs move.
        @(negedge clk);
        op1 = 32'd10; op2 = 32'd5; ALUop = 4'd0;
        @(posedge clk); #1;
        chk("reg_result_q", ALUresult_q, 32'd15);
        chk("reg_zero_q", {31'b0, zero_q}, 32'd0);
        op1 = 32'd7; op2 = 32'd7; ALUop = 4'd1;
        #1;
        chk("hold_result_q", ALUresult_q, 32'd15);
        chk("hold_comb", ALUresult, 32'd0);
        chk("hold_comb_zero", {31'b0, zero}, 32'd1);

        // Async reset between edges clears only the registered outputs.
        op1 = 32'd10; op2 = 32'd5; ALUop = 4'd0;
        #1;
        rst = 1'b1;
        #1;
        chk("async_result_q", ALUresult_q, 32'd0);
        chk("async_zero_q", {31'b0, zero_q}, 32'd0);
        chk("async_comb", ALUresult, 32'd15);
        @(negedge clk);
        rst = 1'b0;
        chk("async_still_clear", ALUresult_q, 32'd0);
        @(posedge clk); #1;
        chk("reload_result_q", ALUresult_q, 32'd15);
        chk("reload_zero_q", {31'b0, zero_q}, 32'd0);

        // Randomized operations, checking both paths each cycle.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            op1 = $urandom;
            op2 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            ALUop = 4'($urandom_range(0, 15));
            e = model(op1, op2, ALUop);
            #1;
            $display("rnd %0d: op=%0d a=%h b=%h -> res=%h exp=%h", i, ALUop, op1, op2,
                     ALUresult, e);
            chk("rnd_result", ALUresult, e);
            chk("rnd_zero", {31'b0, zero}, {31'b0, e == 32'd0});
            @(posedge clk); #1;
            chk("rnd_result_q", ALUresult_q, e);
            chk("rnd_zero_q", {31'b0, zero_q}, {31'b0, e == 32'd0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
